// File: rtl/fds_coord_fetch.sv
// Generates 8.8 source coordinates in output raster order and fetches each sample's 2x2 source
// neighbourhood for the bilinear interpolator. Optional macro FDS_CELL_REUSE_EN skips refetching a repeated cell.
module fds_coord_fetch #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned COORD_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [7:0]         in_w,
   input  logic [7:0]         in_h,
   input  logic [7:0]         out_w,
   input  logic [7:0]         out_h,
   input  logic [15:0]        step_x,
   input  logic [15:0]        step_y,
   output logic               mem_rd_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [DATA_W-1:0]  mem_rd_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y,
   output logic [DATA_W-1:0]  out_a1,
   output logic [DATA_W-1:0]  out_a2,
   output logic [DATA_W-1:0]  out_a3,
   output logic [DATA_W-1:0]  out_a4,
   output logic               out_last,
   output logic               busy,
   output logic               done
);

   localparam int unsigned FRAC_W = 8;
   localparam int unsigned IDX_W  = 8;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD0  = 3'd1;
   localparam logic [2:0] S_RD1  = 3'd2;
   localparam logic [2:0] S_RD2  = 3'd3;
   localparam logic [2:0] S_RD3  = 3'd4;
   localparam logic [2:0] S_WAIT = 3'd5;
   localparam logic [2:0] S_OUT  = 3'd6;
   localparam logic [2:0] S_DONE = 3'd7;

   logic [2:0]         state, state_nxt;
   logic [ADDR_W-1:0]  cfg_base, cfg_base_nxt;
   logic [IDX_W-1:0]   cfg_in_w, cfg_in_w_nxt;
   logic [IDX_W-1:0]   cfg_in_h, cfg_in_h_nxt;
   logic [IDX_W-1:0]   cfg_out_w, cfg_out_w_nxt;
   logic [IDX_W-1:0]   cfg_out_h, cfg_out_h_nxt;
   logic [15:0]        cfg_step_x, cfg_step_x_nxt;
   logic [15:0]        cfg_step_y, cfg_step_y_nxt;
   logic [IDX_W-1:0]   ox, ox_nxt, oy, oy_nxt;
   logic [COORD_W-1:0] ax, ax_nxt, ay, ay_nxt;
   logic [DATA_W-1:0]  a1_nxt, a2_nxt, a3_nxt, a4_nxt;
   logic               mem_rd_en_nxt;
   logic [ADDR_W-1:0]  mem_addr_nxt;
   logic               out_valid_nxt, out_last_nxt;
   logic [COORD_W-1:0] out_x_nxt, out_y_nxt;
   logic               busy_nxt, done_nxt;

   logic               rd_issue, go_rd0, enter_out;
   logic [1:0]         rd_sel;
   logic [IDX_W-1:0]   lim_w, lim_h, ax_int, ay_int;
   logic [IDX_W-1:0]   xi, xi1, yi, yi1;
   logic [15:0]        row0, row1;
   logic [ADDR_W-1:0]  addr_00, addr_01, addr_10, addr_11;

`ifdef FDS_CELL_REUSE_EN
   logic [IDX_W-1:0]   prev_xi, prev_xi_nxt, prev_yi, prev_yi_nxt;
   logic               prev_ok, prev_ok_nxt, reuse, reuse_nxt;
`endif

   // Next-state, datapath and output decode
   always_comb begin
      state_nxt      = state;
      cfg_base_nxt   = cfg_base;
      cfg_in_w_nxt   = cfg_in_w;
      cfg_in_h_nxt   = cfg_in_h;
      cfg_out_w_nxt  = cfg_out_w;
      cfg_out_h_nxt  = cfg_out_h;
      cfg_step_x_nxt = cfg_step_x;
      cfg_step_y_nxt = cfg_step_y;
      ox_nxt         = ox;
      oy_nxt         = oy;
      ax_nxt         = ax;
      ay_nxt         = ay;
      a1_nxt         = out_a1;
      a2_nxt         = out_a2;
      a3_nxt         = out_a3;
      a4_nxt         = out_a4;
      mem_rd_en_nxt  = 1'b0;
      mem_addr_nxt   = mem_addr;
      out_valid_nxt  = out_valid;
      out_x_nxt      = out_x;
      out_y_nxt      = out_y;
      out_last_nxt   = out_last;
      busy_nxt       = busy;
      done_nxt       = 1'b0;
      rd_issue       = 1'b0;
      rd_sel         = 2'd0;
      go_rd0         = 1'b0;
      enter_out      = 1'b0;
`ifdef FDS_CELL_REUSE_EN
      prev_xi_nxt    = prev_xi;
      prev_yi_nxt    = prev_yi;
      prev_ok_nxt    = prev_ok;
      reuse_nxt      = reuse;
`endif

      case (state)
         S_IDLE: begin
            if (start) begin
               cfg_base_nxt   = base_addr;
               cfg_in_w_nxt   = in_w;
               cfg_in_h_nxt   = in_h;
               cfg_out_w_nxt  = out_w;
               cfg_out_h_nxt  = out_h;
               cfg_step_x_nxt = step_x;
               cfg_step_y_nxt = step_y;
               ox_nxt         = '0;
               oy_nxt         = '0;
               ax_nxt         = '0;
               ay_nxt         = '0;
               busy_nxt       = 1'b1;
`ifdef FDS_CELL_REUSE_EN
               prev_ok_nxt    = 1'b0;
               reuse_nxt      = 1'b0;
`endif
               if ((out_w == 8'd0) || (out_h == 8'd0)) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_RD0;
                  go_rd0    = 1'b1;
               end
            end
         end
         S_RD0: begin
`ifdef FDS_CELL_REUSE_EN
            if (reuse) begin
               reuse_nxt = 1'b0;
               state_nxt = S_OUT;
               enter_out = 1'b1;
            end else begin
               state_nxt = S_RD1;
               rd_issue  = 1'b1;
               rd_sel    = 2'd1;
            end
`else
            state_nxt = S_RD1;
            rd_issue  = 1'b1;
            rd_sel    = 2'd1;
`endif
         end
         S_RD1: begin
            a1_nxt    = mem_rd_data;
            state_nxt = S_RD2;
            rd_issue  = 1'b1;
            rd_sel    = 2'd2;
         end
         S_RD2: begin
            a2_nxt    = mem_rd_data;
            state_nxt = S_RD3;
            rd_issue  = 1'b1;
            rd_sel    = 2'd3;
         end
         S_RD3: begin
            a3_nxt    = mem_rd_data;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            a4_nxt    = mem_rd_data;
            state_nxt = S_OUT;
            enter_out = 1'b1;
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_nxt = 1'b0;
               out_last_nxt  = 1'b0;
               if (out_last) begin
                  state_nxt = S_DONE;
               end else begin
                  if (ox == cfg_out_w - 8'd1) begin
                     ox_nxt = '0;
                     ax_nxt = '0;
                     oy_nxt = oy + 8'd1;
                     ay_nxt = ay + COORD_W'(cfg_step_y);
                  end else begin
                     ox_nxt = ox + 8'd1;
                     ax_nxt = ax + COORD_W'(cfg_step_x);
                  end
                  state_nxt = S_RD0;
                  go_rd0    = 1'b1;
               end
            end
         end
         S_DONE: begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      // Clamped source cell of the sample being fetched, from the post-update accumulators
      lim_w   = cfg_in_w_nxt - 8'd1;
      lim_h   = cfg_in_h_nxt - 8'd1;
      ax_int  = ax_nxt[FRAC_W +: IDX_W];
      ay_int  = ay_nxt[FRAC_W +: IDX_W];
      xi      = (ax_int > lim_w) ? lim_w : ax_int;
      yi      = (ay_int > lim_h) ? lim_h : ay_int;
      xi1     = (xi == lim_w) ? xi : xi + 8'd1;
      yi1     = (yi == lim_h) ? yi : yi + 8'd1;
      row0    = 16'(yi) * 16'(cfg_in_w_nxt);
      row1    = 16'(yi1) * 16'(cfg_in_w_nxt);
      addr_00 = cfg_base_nxt + ADDR_W'(row0) + ADDR_W'(xi);
      addr_01 = cfg_base_nxt + ADDR_W'(row1) + ADDR_W'(xi);
      addr_10 = cfg_base_nxt + ADDR_W'(row0) + ADDR_W'(xi1);
      addr_11 = cfg_base_nxt + ADDR_W'(row1) + ADDR_W'(xi1);

      if (go_rd0) begin
`ifdef FDS_CELL_REUSE_EN
         if (prev_ok_nxt && (xi == prev_xi) && (yi == prev_yi)) begin
            reuse_nxt = 1'b1;
         end else begin
            rd_issue = 1'b1;
            rd_sel   = 2'd0;
         end
`else
         rd_issue = 1'b1;
         rd_sel   = 2'd0;
`endif
      end

      if (rd_issue) begin
         mem_rd_en_nxt = 1'b1;
         case (rd_sel)
            2'd0:    mem_addr_nxt = addr_00;
            2'd1:    mem_addr_nxt = addr_01;
            2'd2:    mem_addr_nxt = addr_10;
            default: mem_addr_nxt = addr_11;
         endcase
      end

      if (enter_out) begin
         out_valid_nxt = 1'b1;
         out_x_nxt     = (ax_int > lim_w) ? COORD_W'({lim_w, 8'h00}) : ax_nxt;
         out_y_nxt     = (ay_int > lim_h) ? COORD_W'({lim_h, 8'h00}) : ay_nxt;
         out_last_nxt  = (ox == cfg_out_w - 8'd1) && (oy == cfg_out_h - 8'd1);
`ifdef FDS_CELL_REUSE_EN
         prev_xi_nxt   = xi;
         prev_yi_nxt   = yi;
         prev_ok_nxt   = 1'b1;
`endif
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cfg_base   <= '0;
         cfg_in_w   <= '0;
         cfg_in_h   <= '0;
         cfg_out_w  <= '0;
         cfg_out_h  <= '0;
         cfg_step_x <= '0;
         cfg_step_y <= '0;
         ox         <= '0;
         oy         <= '0;
         ax         <= '0;
         ay         <= '0;
         out_a1     <= '0;
         out_a2     <= '0;
         out_a3     <= '0;
         out_a4     <= '0;
         mem_rd_en  <= 1'b0;
         mem_addr   <= '0;
         out_valid  <= 1'b0;
         out_x      <= '0;
         out_y      <= '0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef FDS_CELL_REUSE_EN
         prev_xi    <= '0;
         prev_yi    <= '0;
         prev_ok    <= 1'b0;
         reuse      <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         cfg_base   <= cfg_base_nxt;
         cfg_in_w   <= cfg_in_w_nxt;
         cfg_in_h   <= cfg_in_h_nxt;
         cfg_out_w  <= cfg_out_w_nxt;
         cfg_out_h  <= cfg_out_h_nxt;
         cfg_step_x <= cfg_step_x_nxt;
         cfg_step_y <= cfg_step_y_nxt;
         ox         <= ox_nxt;
         oy         <= oy_nxt;
         ax         <= ax_nxt;
         ay         <= ay_nxt;
         out_a1     <= a1_nxt;
         out_a2     <= a2_nxt;
         out_a3     <= a3_nxt;
         out_a4     <= a4_nxt;
         mem_rd_en  <= mem_rd_en_nxt;
         mem_addr   <= mem_addr_nxt;
         out_valid  <= out_valid_nxt;
         out_x      <= out_x_nxt;
         out_y      <= out_y_nxt;
         out_last   <= out_last_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
`ifdef FDS_CELL_REUSE_EN
         prev_xi    <= prev_xi_nxt;
         prev_yi    <= prev_yi_nxt;
         prev_ok    <= prev_ok_nxt;
         reuse      <= reuse_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_fds_coord_fetch.sv
// Directed bench for fds_coord_fetch: SRAM model returns mem[a] = a[7:0] one cycle after each read.
module tb_fds_coord_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] base_addr = '0;
   logic [7:0]  in_w = '0, in_h = '0, out_w = '0, out_h = '0;
   logic [15:0] step_x = '0, step_y = '0;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rd_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_x, out_y;
   logic [7:0]  out_a1, out_a2, out_a3, out_a4;
   logic        out_last, busy, done;

   int n_tests = 0;
   int n_fail  = 0;
   int rd_cnt  = 0;

   logic [15:0] s_x  [64];
   logic [15:0] s_y  [64];
   logic [7:0]  s_a1 [64];
   logic [7:0]  s_a2 [64];
   logic [7:0]  s_a3 [64];
   logic [7:0]  s_a4 [64];
   logic        s_last [64];
   int n_s, first_k, second_k, last_k, done_k, reads;

   fds_coord_fetch dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .in_w(in_w), .in_h(in_h), .out_w(out_w), .out_h(out_h),
      .step_x(step_x), .step_y(step_y),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y),
      .out_a1(out_a1), .out_a2(out_a2), .out_a3(out_a3), .out_a4(out_a4),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // SRAM model; 8'hEE on idle cycles exposes mistimed captures
   always @(posedge clk) begin
      mem_rd_data <= mem_rd_en ? mem_addr[7:0] : 8'hEE;
      if (mem_rd_en) rd_cnt <= rd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Runs one plane with out_ready=1; k counts negedges after the start edge
   task automatic run_plane(input logic [15:0] b, input logic [7:0] iw, input logic [7:0] ih,
                            input logic [7:0] ow, input logic [7:0] oh,
                            input logic [15:0] sx, input logic [15:0] sy);
      int r0;
      r0 = rd_cnt;
      base_addr = b; in_w = iw; in_h = ih; out_w = ow; out_h = oh;
      step_x = sx; step_y = sy;
      out_ready = 1'b1;
      start = 1'b1;
      n_s = 0; first_k = -1; second_k = -1; last_k = -1; done_k = -1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 600; k++) begin
         if (out_valid) begin
            if (n_s < 64) begin
               s_x[n_s] = out_x; s_y[n_s] = out_y;
               s_a1[n_s] = out_a1; s_a2[n_s] = out_a2;
               s_a3[n_s] = out_a3; s_a4[n_s] = out_a4;
               s_last[n_s] = out_last;
            end
            if (n_s == 0) first_k = k;
            else if (n_s == 1) second_k = k;
            last_k = k;
            n_s++;
         end
         if (done) begin
            done_k = k;
            break;
         end
         @(negedge clk);
      end
      reads = rd_cnt - r0;
      out_ready = 1'b0;
      if (done_k < 0) chk("plane_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] sn_x, sn_y;
      logic [31:0] sn_a;
      logic        stable;
      int          nrd, kv, ndone;

      repeat (2) @(negedge clk);
      chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_out_x", 32'(out_x), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Identity 4x4 -> 4x4
      run_plane(16'h0100, 8'd4, 8'd4, 8'd4, 8'd4, 16'h0100, 16'h0100);
      chk("id_count",   32'(n_s), 32'd16);
      chk("id_latency", 32'(first_k), 32'd6);
      chk("id_period",  32'(second_k - first_k), 32'd6);
      chk("id_s0_a2",   32'(s_a2[0]), 32'h04);
      chk("id_s0_a3",   32'(s_a3[0]), 32'h01);
      chk("id_s9_x",    32'(s_x[9]), 32'h0100);
      chk("id_s9_y",    32'(s_y[9]), 32'h0200);
      chk("id_s9_a",    {s_a1[9], s_a2[9], s_a3[9], s_a4[9]}, 32'h090D0A0E);
      chk("id_last14",  32'(s_last[14]), 32'd0);
      chk("id_last15",  32'(s_last[15]), 32'd1);
      chk("id_done_gap", 32'(done_k - last_k), 32'd2);
      chk("id_reads",   32'(reads), 32'd64);

      // Downsample 8x8 -> 5x5, step 1.6
      run_plane(16'h0200, 8'd8, 8'd8, 8'd5, 8'd5, 16'h019A, 16'h019A);
      chk("ds_count", 32'(n_s), 32'd25);
      chk("ds_s3_x",  32'(s_x[3]), 32'h04CE);
      chk("ds_s3_a",  {s_a1[3], s_a2[3], s_a3[3], s_a4[3]}, 32'h040C050D);
      chk("ds_s23_y", 32'(s_y[23]), 32'h0668);
      chk("ds_s23_a", {s_a1[23], s_a2[23], s_a3[23], s_a4[23]}, 32'h343C353D);
      chk("ds_s24_a", {s_a1[24], s_a2[24], s_a3[24], s_a4[24]}, 32'h363E373F);

      // Right/bottom edge clamp 4x4 -> 3x3, step 1.5
      run_plane(16'h0100, 8'd4, 8'd4, 8'd3, 8'd3, 16'h0180, 16'h0180);
      chk("ec_count", 32'(n_s), 32'd9);
      chk("ec_s2_x",  32'(s_x[2]), 32'h0300);
      chk("ec_s2_a",  {s_a1[2], s_a2[2], s_a3[2], s_a4[2]}, 32'h03070307);
      chk("ec_s8_y",  32'(s_y[8]), 32'h0300);
      chk("ec_s8_a",  {s_a1[8], s_a2[8], s_a3[8], s_a4[8]}, 32'h0F0F0F0F);

      // Integer part past the edge: out_x saturates to in_w-1
      run_plane(16'h0100, 8'd4, 8'd4, 8'd3, 8'd1, 16'h0200, 16'h0000);
      chk("xc_count", 32'(n_s), 32'd3);
      chk("xc_s2_x",  32'(s_x[2]), 32'h0300);
      chk("xc_s2_a",  {s_a1[2], s_a2[2], s_a3[2], s_a4[2]}, 32'h03070307);
      chk("xc_last",  32'(s_last[2]), 32'd1);

      // Degenerate plane
      run_plane(16'h0100, 8'd4, 8'd4, 8'd0, 8'd4, 16'h0100, 16'h0100);
      chk("dg_done_k", 32'(done_k), 32'd2);
      chk("dg_reads",  32'(reads), 32'd0);
      chk("dg_count",  32'(n_s), 32'd0);

      // Backpressure: hold ready low in OUT
      base_addr = 16'h0100; in_w = 8'd4; in_h = 8'd4; out_w = 8'd4; out_h = 8'd4;
      step_x = 16'h0100; step_y = 16'h0100; out_ready = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      kv = 1;
      while (!out_valid && kv < 30) begin
         @(negedge clk);
         kv++;
      end
      chk("bp_latency", 32'(kv), 32'd6);
      sn_x = out_x; sn_y = out_y;
      sn_a = {out_a1, out_a2, out_a3, out_a4};
      stable = 1'b1; nrd = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_x !== sn_x || out_y !== sn_y ||
             {out_a1, out_a2, out_a3, out_a4} !== sn_a) stable = 1'b0;
         if (mem_rd_en) nrd++;
      end
      chk("bp_stable",  32'(stable), 32'd1);
      chk("bp_no_read", 32'(nrd), 32'd0);
      chk("bp_snap_a",  sn_a, 32'h00040105);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_drop", 32'(out_valid), 32'd0);
      chk("bp_rd0",  32'(mem_rd_en), 32'd1);
      repeat (2) @(negedge clk);
      chk("bp_rd2_addr", 32'(mem_addr), 32'h0102);

      // Abort during RD2
      rst = 1'b1;
      #1;
      chk("ab_rd_en", 32'(mem_rd_en), 32'd0);
      chk("ab_addr",  32'(mem_addr), 32'd0);
      chk("ab_busy",  32'(busy), 32'd0);
      chk("ab_data",  {out_x, out_a1, out_a2}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      repeat (6) begin
         @(negedge clk);
         if (done || busy || mem_rd_en) ndone++;
      end
      chk("ab_quiet", 32'(ndone), 32'd0);

      run_plane(16'h0100, 8'd4, 8'd4, 8'd4, 8'd4, 16'h0100, 16'h0100);
      chk("ab_rerun_count", 32'(n_s), 32'd16);
      chk("ab_rerun_s0",    {s_x[0], s_y[0]}, 32'd0);
      chk("ab_rerun_s0_a",  {s_a1[0], s_a2[0], s_a3[0], s_a4[0]}, 32'h00040105);

      // Upsample 2x2 -> 4x4, step 0.5
      run_plane(16'h0100, 8'd2, 8'd2, 8'd4, 8'd4, 16'h0080, 16'h0080);
      chk("up_count", 32'(n_s), 32'd16);
      chk("up_s1_x",  32'(s_x[1]), 32'h0080);
      chk("up_s1_a",  {s_a1[1], s_a2[1], s_a3[1], s_a4[1]}, 32'h00020103);
      chk("up_s15_a", {s_a1[15], s_a2[15], s_a3[15], s_a4[15]}, 32'h03030303);
`ifdef FDS_CELL_REUSE_EN
      chk("up_reads", 32'(reads), 32'd32);
      chk("up_gap",   32'(second_k - first_k), 32'd2);
`else
      chk("up_reads", 32'(reads), 32'd64);
      chk("up_gap",   32'(second_k - first_k), 32'd6);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fds_coord_fetch.md
Name: fds_coord_fetch

Overview:
Address-generation and pixel-fetch stage directly upstream of the bilinear interpolator in the flexible-downsampling path. For each output sample in raster order it:
- computes the 8.8 fixed-point source coordinate,
- reads the four neighbouring pixels from the feature-map SRAM,
- presents coordinate plus neighbours (a1..a4) over a valid/ready handshake.
One channel plane per start.

Parameters:
DATA_W, 8, pixel width (matches interpolator a1..a4)
ADDR_W, 16, SRAM word address width
COORD_W, 16, coordinate width, 8.8 fixed-point

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; latches config, begins plane
base_addr  in  ADDR_W  address of pixel (0,0)
in_w  in  8  source width minus 0 (1..255)
in_h  in  8  source height (1..255)
out_w  in  8  output width
out_h  in  8  output height
step_x  in  16  8.8 horizontal step (in/out ratio)
step_y  in  16  8.8 vertical step
mem_rd_en  out  1  SRAM read strobe
mem_addr  out  ADDR_W  SRAM read address
mem_rd_data  in  DATA_W  SRAM data, valid exactly 1 cycle after mem_rd_en
out_valid  out  1  sample valid to interpolator
out_ready  in  1  interpolator accepts
out_x  out  16  8.8 x coordinate
out_y  out  16  8.8 y coordinate
out_a1/out_a2/out_a3/out_a4  out  DATA_W each  pixels at (xi,yi) / (xi,yi1) / (xi1,yi) / (xi1,yi1)
out_last  out  1  final sample of plane, qualified by out_valid
busy  out  1  plane in progress
done  out  1  one-cycle pulse at plane completion

Behaviour:
- Reset (async, rst=1): FSM to IDLE; all outputs 0, including mem_rd_en, out_valid, busy, done, data/coord registers, and counters.
- States: IDLE, RD0, RD1, RD2, RD3, WAIT, OUT, DONE.
- IDLE:
  - On start, latch all config, clear ox=oy=0 and the accumulators ax=ay=0, busy=1.
  - If out_w==0 or out_h==0, go to DONE; otherwise go to RD0.
  - start is ignored outside IDLE.
- Coordinate clamping: xi=min(ax[15:8], in_w-1); xi1=min(xi+1, in_w-1); yi and yi1 are formed likewise from ay and in_h.
- Coordinate output: out_x=ax, except when ax[15:8]>in_w-1, in which case out_x={in_w-1, 8'h00}. out_y is formed the same way.
- Reads, one per state, address = base_addr + row*in_w + col (ADDR_W wrap, no saturation):
  - RD0 reads (xi,yi).
  - RD1 reads (xi,yi1).
  - RD2 reads (xi1,yi).
  - RD3 reads (xi1,yi1).
- Data capture: mem_rd_data is captured one cycle after each read, in RD1, RD2, RD3 and WAIT respectively, into a1, a2, a3, a4. WAIT then goes to OUT.
- Latency: out_valid rises 5 cycles after entering RD0.
- OUT:
  - out_valid=1; outputs held stable until out_ready.
  - On handshake, advance: ox++, ax+=step_x. When ox==out_w-1: ox=0, ax=0, oy++, ay+=step_y.
  - out_last=1 when ox==out_w-1 and oy==out_h-1; on that handshake go to DONE, otherwise go to RD0.
  - out_valid drops in the cycle after the handshake.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Accumulator overflow past 16 bits is not permitted; config guarantees (out-1)*step < 256.0.
- rst asserted mid-plane aborts immediately. The in-flight SRAM read is discarded and no done pulse is issued.

Optional Feature:
FDS_CELL_REUSE_EN:
- Defined: in RD0, if the clamped (xi,yi) equals that of the previously emitted sample in the same plane, issue no reads, keep a1..a4, and go directly to OUT. Latency is 1 cycle. This benefits upsampling (step<1.0). The first sample of each plane always fetches.
- Undefined: every sample performs all four reads.

Test Plan:
- Reset mid-plane: rst pulse during RD2 -> all outputs 0 within the same cycle; busy=0; no done; a subsequent start runs correctly from (0,0).
- Identity 4x4 -> 4x4 (step 0x0100), base 0x0100, mem[a]=a[7:0], out_ready=1 -> 16 samples.
  - Sample (1,2): out_x=0x0100, out_y=0x0200, a1=0x09, a2=0x0D, a3=0x0A, a4=0x0E.
  - out_last on the 16th sample; done one cycle later.
- Downsample 8x8 -> 5x5, step 0x019A -> fourth sample out_x=0x04CE, xi=4, xi1=5.
  - Last row: yi=6 (from 0x0668), yi1=7.
- Edge clamp: 4x4 -> 3x3, step 0x0180 -> third sample out_x=0x0300, xi=xi1=3, so a1==a3 and a2==a4.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_valid and all outputs stable, no mem_rd_en; advance only on the ready cycle.
- Degenerate/reuse cases:
  - out_w=0 -> done 2 cycles after start, no reads.
  - With FDS_CELL_REUSE_EN, 2x2 -> 4x4 at step 0x0080: 8 fetch groups instead of 16. Sample (1,0) has zero mem_rd_en and out_valid one cycle after the prior handshake.
